// File: rtl/mem_req_issuer.sv
// +----------------------------------------------------------------------------+
// | mem_req_issuer : issues CPU loads/stores to the RAM1/UART controller,      |
// |                  stalls until completion, answers status reads locally.    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module mem_req_issuer #(
    parameter int          ACT_W       = 2,
    parameter int          QW          = 4,
    parameter logic [15:0] UART_ADDR   = 16'hBF00,
    parameter logic [15:0] STAT_ADDR   = 16'hBF01,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    output logic             stall,
    output logic [15:0]      rdata,
    output logic             rdata_valid,
    output logic             bus_err,
    output logic [15:0]      err_count,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_value,
    output logic [ACT_W-1:0] mem_act,
    input  logic             uart_work_done,
    input  logic [ACT_W-1:0] mem_act_out,
    input  logic [15:0]      result,
    input  logic [QW-1:0]    front,
    input  logic [QW-1:0]    tail
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 2;
    localparam logic [TW-1:0] c_TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STAT  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic             r_is_load;

    logic             r_done_s1, r_done_s2;
    logic [ACT_W-1:0] r_act_s1, r_act_s2;
    logic [15:0]      r_result_s1, r_result_s2;
    logic [QW-1:0]    r_front_s1, r_front_s2;
    logic [QW-1:0]    r_tail_s1, r_tail_s2;

    logic w_req;
    logic w_stat_hit;
    logic w_done_s;

    assign w_req = req_valid && (req_rd || req_wr);
    // If both addresses were ever configured equal, the UART data path wins.
    assign w_stat_hit = (req_addr == STAT_ADDR) && (STAT_ADDR != UART_ADDR);
    assign w_done_s   = r_done_s2 && (r_act_s2 == mem_act);
    assign stall      = rst && w_req && !rdata_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_s1   <= 1'b0;
            r_done_s2   <= 1'b0;
            r_act_s1    <= '0;
            r_act_s2    <= '0;
            r_result_s1 <= '0;
            r_result_s2 <= '0;
            r_front_s1  <= '0;
            r_front_s2  <= '0;
            r_tail_s1   <= '0;
            r_tail_s2   <= '0;
        end else begin
            r_done_s1   <= uart_work_done;
            r_done_s2   <= r_done_s1;
            r_act_s1    <= mem_act_out;
            r_act_s2    <= r_act_s1;
            r_result_s1 <= result;
            r_result_s2 <= r_result_s1;
            r_front_s1  <= front;
            r_front_s2  <= r_front_s1;
            r_tail_s1   <= tail;
            r_tail_s2   <= r_tail_s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_is_load   <= 1'b0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            err_count   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_value   <= '0;
            mem_act     <= '0;
        end else begin
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The retire cycle still shows the old request; skip it.
                    if (w_req && !rdata_valid) begin
                        if (w_stat_hit) begin
                            r_state <= S_STAT;
                        end else begin
                            mem_addr  <= req_addr;
                            mem_value <= req_wdata;
                            r_is_load <= !req_wr;
                            mem_act   <= mem_act + 1'b1;
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_STAT: begin
                    rdata       <= {14'b0, (r_front_s2 != r_tail_s2), 1'b1};
                    rdata_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_ISSUE: begin
                    mem_rd  <= r_is_load;
                    mem_wr  <= !r_is_load;
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_done_s) begin
                        r_state <= S_DONE;
                    end else if (r_timer == c_TIMER_LAST) begin
                        r_state <= S_ABORT;
                    end
                end
                S_DONE: begin
                    rdata       <= r_is_load ? r_result_s2 : 16'h0000;
                    rdata_valid <= 1'b1;
                    mem_rd      <= 1'b0;
                    mem_wr      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                S_ABORT: begin
                    rdata       <= 16'hFFFF;
                    rdata_valid <= 1'b1;
                    bus_err     <= 1'b1;
                    if (err_count != 16'hFFFF) begin
                        err_count <= err_count + 1'b1;
                    end
                    mem_rd      <= 1'b0;
                    mem_wr      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
